// File: rtl/game_pkg.sv
// game_pkg: board geometry, default mine counts, level and defuse FSM encodings.
package game_pkg;
    localparam int SIZE_EASY = 8;
    localparam int SIZE_MEDIUM = 10;
    localparam int SIZE_HARD = 16;
    localparam int MINES_EASY_DEF = 10;
    localparam int MINES_MEDIUM_DEF = 20;
    localparam int MINES_HARD_DEF = 40;
    typedef enum logic [1:0] {LVL_NONE, LVL_EASY, LVL_MEDIUM, LVL_HARD} level_t;
    typedef enum logic {IDLE, CLEAR} defuse_state_t;
    function automatic logic [4:0] board_size(input logic [1:0] l);
        return l == LVL_EASY ? 5'(SIZE_EASY) : l == LVL_MEDIUM ? 5'(SIZE_MEDIUM) :
               l == LVL_HARD ? 5'(SIZE_HARD) : 5'd0;
    endfunction
endpackage

// File: rtl/defuse_ctl.sv
// defuse_ctl: per-level flag arrays with row-sweep clear and a flags-left counter.
// DEFUSE_LIMIT_EN: when defined, flag placement is refused once no flags remain.
module defuse_ctl
    import game_pkg::*;
#(
    parameter int MINES_EASY = MINES_EASY_DEF,
    parameter int MINES_MEDIUM = MINES_MEDIUM_DEF,
    parameter int MINES_HARD = MINES_HARD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        level,
    input  logic              new_game,
    input  logic              click_valid,
    input  logic [3:0]        click_x,
    input  logic [3:0]        click_y,
    input  logic              click_revealed,
    output logic              busy,
    output logic [6:0]        flags_left,
    output logic [7:0][7:0]   defuse_arr_easy,
    output logic [9:0][9:0]   defuse_arr_medium,
    output logic [15:0][15:0] defuse_arr_hard
);
    defuse_state_t state;
    logic [3:0] row;
    logic [4:0] size;
    logic [6:0] mines;
    logic cur, in_range, limit_ok, accept;

    function automatic logic [6:0] mines_for(input logic [1:0] l);
        return l == LVL_EASY ? 7'(MINES_EASY) : l == LVL_MEDIUM ? 7'(MINES_MEDIUM) :
               l == LVL_HARD ? 7'(MINES_HARD) : 7'd0;
    endfunction

    always_comb begin
        size = board_size(level);
        mines = mines_for(level);
        // level NONE has size 0, so no coordinate is ever in range
        in_range = ({1'b0, click_x} < size) && ({1'b0, click_y} < size);
        cur = level == LVL_EASY ? defuse_arr_easy[click_x[2:0]][click_y[2:0]] :
              level == LVL_MEDIUM ? defuse_arr_medium[click_x][click_y] :
              defuse_arr_hard[click_x][click_y];
`ifdef DEFUSE_LIMIT_EN
        limit_ok = cur || flags_left != 7'd0;
`else
        limit_ok = 1'b1;
`endif
        accept = click_valid && !new_game && state == IDLE && !click_revealed && in_range && limit_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row <= '0;
            busy <= 1'b0;
            flags_left <= '0;
            defuse_arr_easy <= '0;
            defuse_arr_medium <= '0;
            defuse_arr_hard <= '0;
        end else if (new_game) begin
            state <= CLEAR;
            row <= '0;
            busy <= 1'b1;
            flags_left <= mines;
        end else if (state == CLEAR) begin
            if (row < 4'(SIZE_EASY)) defuse_arr_easy[row[2:0]] <= '0;
            if (row < 4'(SIZE_MEDIUM)) defuse_arr_medium[row] <= '0;
            defuse_arr_hard[row] <= '0;
            row <= row + 4'd1;
            if (row == 4'(SIZE_HARD - 1)) begin
                state <= IDLE;
                busy <= 1'b0;
            end
        end else if (accept) begin
            if (level == LVL_EASY) defuse_arr_easy[click_x[2:0]][click_y[2:0]] <= !cur;
            if (level == LVL_MEDIUM) defuse_arr_medium[click_x][click_y] <= !cur;
            if (level == LVL_HARD) defuse_arr_hard[click_x][click_y] <= !cur;
            flags_left <= !cur ? (flags_left == 7'd0 ? 7'd0 : flags_left - 7'd1) :
                          (flags_left >= mines ? mines : flags_left + 7'd1);
        end
    end
endmodule

// File: tb/tb_defuse_ctl.sv
// tb_defuse_ctl: directed stimulus with a queued scoreboard checked by a separate monitor.
module tb_defuse_ctl;
    logic clk = 1'b0, rst = 1'b1, new_game = 1'b0, click_valid = 1'b0, click_revealed = 1'b0;
    logic [1:0] level = 2'd0;
    logic [3:0] click_x = '0, click_y = '0;
    logic busy;
    logic [6:0] flags_left;
    logic [7:0][7:0] defuse_arr_easy;
    logic [9:0][9:0] defuse_arr_medium;
    logic [15:0][15:0] defuse_arr_hard;

    defuse_ctl dut (
        .clk(clk), .rst(rst), .level(level), .new_game(new_game), .click_valid(click_valid),
        .click_x(click_x), .click_y(click_y), .click_revealed(click_revealed), .busy(busy),
        .flags_left(flags_left), .defuse_arr_easy(defuse_arr_easy),
        .defuse_arr_medium(defuse_arr_medium), .defuse_arr_hard(defuse_arr_hard)
    );

    always #5 clk = ~clk;

    // kind: 0 flags_left, 1 busy, 2 easy bit, 3 medium bit, 4 hard bit, 5 all arrays zero
    typedef struct {
        int due;
        string name;
        int kind;
        int x;
        int y;
        int exp;
    } exp_t;
    exp_t q[$];
    int cyc = 0, checks = 0, failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input int kind, input int x, input int y);
        case (kind)
            0: return int'(flags_left);
            1: return int'(busy);
            2: return int'(defuse_arr_easy[x][y]);
            3: return int'(defuse_arr_medium[x][y]);
            4: return int'(defuse_arr_hard[x][y]);
            default: return int'(defuse_arr_easy == '0 && defuse_arr_medium == '0 && defuse_arr_hard == '0);
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int a;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            a = actual(e.kind, e.x, e.y);
            checks++;
            if (a != e.exp) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.exp, cyc);
            end
        end
    end

    task automatic push(input string n, input int k, input int x, input int y, input int e);
        q.push_back('{cyc, n, k, x, y, e});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic click(input int x, input int y, input logic rev);
        click_valid = 1'b1;
        click_x = 4'(x);
        click_y = 4'(y);
        click_revealed = rev;
        step();
        click_valid = 1'b0;
        click_revealed = 1'b0;
    endtask

    task automatic start_game(input int l, input int mines);
        level = 2'(l);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        push("start_busy", 1, 0, 0, 1);
        push("start_flags", 0, 0, 0, mines);
    endtask

    task automatic sweep_rest(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            push("busy_hold", 1, 0, 0, 1);
        end
        step();
        push("busy_end", 1, 0, 0, 0);
        push("swept_zero", 5, 0, 0, 1);
    endtask

    initial begin
        step();
        step();
        push("rst_flags", 0, 0, 0, 0);
        push("rst_busy", 1, 0, 0, 0);
        push("rst_zero", 5, 0, 0, 1);
        rst = 1'b0;
        start_game(1, 10);
        sweep_rest(15);
        click(3, 5, 1'b0);
        push("easy_set", 2, 3, 5, 1);
        push("easy_set_flags", 0, 0, 0, 9);
        click(3, 5, 1'b0);
        push("easy_clr", 2, 3, 5, 0);
        push("easy_clr_flags", 0, 0, 0, 10);
        start_game(2, 20);
        sweep_rest(15);
        click(9, 9, 1'b0);
        push("med_corner", 3, 9, 9, 1);
        push("med_corner_flags", 0, 0, 0, 19);
        click(10, 2, 1'b0);
        push("med_oor_flags", 0, 0, 0, 19);
        push("med_oor_keep", 3, 9, 9, 1);
        start_game(1, 10);
        click(7, 0, 1'b0);
        push("busy_drop_bit", 2, 7, 0, 0);
        push("busy_drop_flags", 0, 0, 0, 10);
        sweep_rest(14);
        click(2, 2, 1'b1);
        push("revealed_drop_bit", 2, 2, 2, 0);
        push("revealed_drop_flags", 0, 0, 0, 10);
        new_game = 1'b1;
        click(2, 2, 1'b0);
        new_game = 1'b0;
        push("coincide_bit", 2, 2, 2, 0);
        push("coincide_flags", 0, 0, 0, 10);
        push("coincide_busy", 1, 0, 0, 1);
        sweep_rest(15);
        for (int i = 0; i < 10; i++) click(i % 8, i / 8, 1'b0);
        push("ten_flags", 0, 0, 0, 0);
        push("tenth_bit", 2, 1, 1, 1);
        click(2, 2, 1'b0);
`ifdef DEFUSE_LIMIT_EN
        push("limit_bit", 2, 2, 2, 0);
`else
        push("limit_bit", 2, 2, 2, 1);
`endif
        push("limit_flags", 0, 0, 0, 0);
        click(0, 0, 1'b0);
        push("unflag_bit", 2, 0, 0, 0);
        push("unflag_flags", 0, 0, 0, 1);
        start_game(3, 40);
        sweep_rest(15);
        click(15, 15, 1'b0);
        push("hard_corner", 4, 15, 15, 1);
        click(3, 3, 1'b0);
        push("hard_flags", 0, 0, 0, 38);
        start_game(3, 40);
        repeat (7) step();
        push("pre_rst_keep", 4, 15, 15, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        push("midrst_flags", 0, 0, 0, 0);
        push("midrst_busy", 1, 0, 0, 0);
        push("midrst_zero", 5, 0, 0, 1);
        step();
        step();
        push("no_residual", 1, 0, 0, 0);
        start_game(3, 40);
        sweep_rest(15);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
